soc_system_level_monitor: RTL and testbench

Parametrised, multi-channel successor to the single-channel FIFO fill-level PIO. It presents NUM_CH synchronous level inputs (FIFO used-words counts or similar) to the HPS over an Avalon-MM slave. Each channel has:
- a live level register,
- a peak-hold (high-watermark) register,
- a programmable threshold with a rising-crossing flag.

Enabled flags are OR-ed onto a single level-sensitive interrupt.

---
 rtl/soc_system_level_monitor_if.sv | 25 ++
 rtl/soc_system_level_monitor.sv | 130 +++++++++++++
 tb/tb_soc_system_level_monitor.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/soc_system_level_monitor_if.sv
// Avalon-MM slave bus bundle for soc_system_level_monitor.
// Carries the address/data path; clock, reset, in_port and irq remain plain ports.
interface soc_system_level_monitor_if;
  logic        chipselect;
  logic        write_n;
  logic [4:0]  address;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output chipselect,
    output write_n,
    output address,
    output writedata,
    input  readdata
  );

  modport slave (
    input  chipselect,
    input  write_n,
    input  address,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/soc_system_level_monitor.sv
// Multi-channel level monitor: per channel live level, peak-hold, threshold and
// rising-crossing flag, exposed over Avalon-MM with a level-sensitive interrupt.
module soc_system_level_monitor #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_CH     = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  soc_system_level_monitor_if.slave    avs,
  input  logic [NUM_CH*DATA_WIDTH-1:0] in_port,
  output logic                         irq
);

  typedef enum logic [1:0] {
    REG_LEVEL  = 2'd0,
    REG_PEAK   = 2'd1,
    REG_THRESH = 2'd2,
    REG_CTRL   = 2'd3
  } reg_e;

  logic [DATA_WIDTH-1:0] level_q  [NUM_CH];
  logic [DATA_WIDTH-1:0] peak_q   [NUM_CH];
  logic [DATA_WIDTH-1:0] thresh_q [NUM_CH];
  logic [NUM_CH-1:0]     above_q;
  logic [NUM_CH-1:0]     flag_q;
  logic [NUM_CH-1:0]     irq_en_q;

  logic [2:0]        sel_ch;
  reg_e              sel_reg;
  logic              wr_en;
  logic [NUM_CH-1:0] ch_hit;
  logic [NUM_CH-1:0] wr_peak;
  logic [NUM_CH-1:0] wr_thresh;
  logic [NUM_CH-1:0] wr_ctrl;
  logic [NUM_CH-1:0] at_or_above;
  logic [NUM_CH-1:0] rising;
  logic [31:0]       rd_mux;
  logic              unused_wdata;

  assign sel_ch  = avs.address[4:2];
  assign sel_reg = reg_e'(avs.address[1:0]);
  assign wr_en   = avs.chipselect & ~avs.write_n;

  // Channels at or beyond NUM_CH never match, so their reads give 0 and writes drop.
  always_comb begin
    ch_hit      = '0;
    wr_peak     = '0;
    wr_thresh   = '0;
    wr_ctrl     = '0;
    at_or_above = '0;
    rising      = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      ch_hit[i]      = (sel_ch == 3'(i));
      wr_peak[i]     = wr_en && ch_hit[i] && (sel_reg == REG_PEAK);
      wr_thresh[i]   = wr_en && ch_hit[i] && (sel_reg == REG_THRESH);
      wr_ctrl[i]     = wr_en && ch_hit[i] && (sel_reg == REG_CTRL);
      at_or_above[i] = (level_q[i] >= thresh_q[i]);
      rising[i]      = at_or_above[i] && !above_q[i];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        level_q[i]  <= '0;
        peak_q[i]   <= '0;
        thresh_q[i] <= '1;
      end
      above_q  <= '0;
      flag_q   <= '0;
      irq_en_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        level_q[i] <= in_port[i*DATA_WIDTH +: DATA_WIDTH];

        if (wr_peak[i]) begin
          peak_q[i] <= level_q[i];
        end else if (level_q[i] > peak_q[i]) begin
          peak_q[i] <= level_q[i];
        end

        above_q[i] <= at_or_above[i];

        // A new crossing outranks a simultaneous write-1-to-clear.
        if (rising[i]) begin
          flag_q[i] <= 1'b1;
        end else if (wr_ctrl[i] && avs.writedata[0]) begin
          flag_q[i] <= 1'b0;
        end

        if (wr_thresh[i]) begin
          thresh_q[i] <= avs.writedata[DATA_WIDTH-1:0];
        end

        if (wr_ctrl[i]) begin
          irq_en_q[i] <= avs.writedata[1];
        end
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (ch_hit[i]) begin
        case (sel_reg)
          REG_LEVEL:  rd_mux[DATA_WIDTH-1:0] = level_q[i];
          REG_PEAK:   rd_mux[DATA_WIDTH-1:0] = peak_q[i];
          REG_THRESH: rd_mux[DATA_WIDTH-1:0] = thresh_q[i];
          REG_CTRL:   rd_mux[1:0]            = {irq_en_q[i], flag_q[i]};
          default:    rd_mux                 = '0;
        endcase
      end
    end
  end

  // Read data is refreshed every edge regardless of chipselect.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      avs.readdata <= '0;
    end else begin
      avs.readdata <= rd_mux;
    end
  end

  assign irq = |(flag_q & irq_en_q);

  assign unused_wdata = ^avs.writedata;

endmodule

// File: tb/tb_soc_system_level_monitor.sv
// Scoreboard bench for soc_system_level_monitor: directed scenarios plus random
// traffic, checked against a behavioural register-map model.
module tb_soc_system_level_monitor;
  localparam int DW  = 16;
  localparam int NCH = 4;

  logic              clk     = 1'b0;
  logic              reset_n = 1'b1;
  logic [NCH*DW-1:0] in_port = '0;
  logic              irq;

  soc_system_level_monitor_if bus ();

  soc_system_level_monitor #(.DATA_WIDTH(DW), .NUM_CH(NCH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .avs     (bus.slave),
    .in_port (in_port),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model: what each register should hold after every edge.
  logic [DW-1:0]  m_level  [NCH];
  logic [DW-1:0]  m_peak   [NCH];
  logic [DW-1:0]  m_thresh [NCH];
  logic [NCH-1:0] m_above;
  logic [NCH-1:0] m_flag;
  logic [NCH-1:0] m_en;

  typedef struct packed {
    logic        has_dir;
    logic [4:0]  addr;
    logic [31:0] dir;
    logic [31:0] model;
  } rd_exp_t;

  rd_exp_t exp_q[$];

  logic        rd_req  = 1'b0;
  logic        dir_has = 1'b0;
  logic [31:0] dir_val = '0;

  function automatic logic [31:0] model_read(input logic [4:0] a);
    int unsigned c;
    c = int'(a[4:2]);
    if (c >= NCH) return '0;
    case (a[1:0])
      2'd0:    return 32'(m_level[c]);
      2'd1:    return 32'(m_peak[c]);
      2'd2:    return 32'(m_thresh[c]);
      default: return {30'b0, m_en[c], m_flag[c]};
    endcase
  endfunction

  function automatic logic wr_to(input int c, input int r);
    return bus.chipselect && !bus.write_n &&
           (int'(bus.address[4:2]) == c) && (int'(bus.address[1:0]) == r);
  endfunction

  function automatic logic model_irq();
    return |(m_flag & m_en);
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < NCH; c++) begin
        m_level[c]  <= '0;
        m_peak[c]   <= '0;
        m_thresh[c] <= '1;
      end
      m_above <= '0;
      m_flag  <= '0;
      m_en    <= '0;
      exp_q.delete();
    end else begin
      if (rd_req) exp_q.push_back(rd_exp_t'({dir_has, bus.address, dir_val, model_read(bus.address)}));
      for (int c = 0; c < NCH; c++) begin
        m_level[c] <= in_port[c*DW +: DW];
        m_peak[c]  <= wr_to(c, 1) ? m_level[c]
                    : ((m_level[c] > m_peak[c]) ? m_level[c] : m_peak[c]);
        m_above[c] <= (m_level[c] >= m_thresh[c]);
        if ((m_level[c] >= m_thresh[c]) && !m_above[c]) m_flag[c] <= 1'b1;
        else if (wr_to(c, 3) && bus.writedata[0])        m_flag[c] <= 1'b0;
        if (wr_to(c, 2)) m_thresh[c] <= bus.writedata[DW-1:0];
        if (wr_to(c, 3)) m_en[c]     <= bus.writedata[1];
      end
    end
  end

  // Monitor: readdata is valid the edge after a read was issued.
  initial begin
    rd_exp_t e;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check($sformatf("readdata_model[addr=%0h]", e.addr), bus.readdata, e.model);
          if (e.has_dir) check($sformatf("readdata_directed[addr=%0h]", e.addr), bus.readdata, e.dir);
        end
        check("irq_model", {31'b0, irq}, {31'b0, model_irq()});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    bus.address    = a;
    bus.writedata  = d;
    tick();
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic rd(input logic [4:0] a, input logic has, input logic [31:0] v);
    bus.address = a;
    rd_req      = 1'b1;
    dir_has     = has;
    dir_val     = v;
    tick();
    rd_req  = 1'b0;
    dir_has = 1'b0;
  endtask

  task automatic set_lvl(input int c, input logic [DW-1:0] v);
    in_port[c*DW +: DW] = v;
  endtask

  initial begin
    int unsigned op;
    logic [31:0] r;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.address    = '0;
    bus.writedata  = '0;

    // Reset with live nonzero inputs
    #1 reset_n = 1'b0;
    in_port = 64'h4444_3333_2222_1111;
    repeat (3) tick();
    check("reset_readdata", bus.readdata, 32'h0);
    check("reset_irq", {31'b0, irq}, 32'h0);
    in_port = '0;
    reset_n = 1'b1;
    rd(5'h02, 1'b1, 32'h0000_FFFF);
    rd(5'h03, 1'b1, 32'h0);

    // Level and peak on channel 1
    set_lvl(1, 5);  tick();
    set_lvl(1, 40); tick();
    set_lvl(1, 12); tick(); tick();
    rd(5'h04, 1'b1, 32'd12);
    rd(5'h05, 1'b1, 32'd40);
    wr(5'h05, 32'hDEAD_BEEF);
    rd(5'h05, 1'b1, 32'd12);
    set_lvl(1, 20); tick(); tick();
    rd(5'h05, 1'b1, 32'd20);

    // Rising crossing on channel 2
    wr(5'h0A, 32'd100);
    wr(5'h0B, 32'd2);
    set_lvl(2, 99); tick(); tick();
    set_lvl(2, 100); tick();
    check("cross_irq_after_E0", {31'b0, irq}, 32'h0);
    tick();
    check("cross_irq_after_E1", {31'b0, irq}, 32'h1);
    rd(5'h0B, 1'b1, 32'd3);
    set_lvl(2, 150); tick(); tick();
    wr(5'h0B, 32'd3);
    check("w1c_irq", {31'b0, irq}, 32'h0);
    tick(); tick();
    rd(5'h0B, 1'b1, 32'd2);
    set_lvl(2, 50); tick(); tick(); tick();
    set_lvl(2, 100); tick(); tick();
    rd(5'h0B, 1'b1, 32'd3);
    check("rearm_irq", {31'b0, irq}, 32'h1);
    wr(5'h0B, 32'd1);
    check("ch2_disable_irq", {31'b0, irq}, 32'h0);

    // Set and clear in the same cycle on channel 0
    wr(5'h02, 32'hABCD_0200);
    rd(5'h02, 1'b1, 32'h0000_0200);
    set_lvl(0, 16'h0300); tick();
    wr(5'h03, 32'd1);
    rd(5'h03, 1'b1, 32'd1);
    check("masked_irq", {31'b0, irq}, 32'h0);

    // Threshold lowered onto the level on channel 3
    wr(5'h0E, 32'd200);
    set_lvl(3, 60); tick(); tick();
    wr(5'h0E, 32'd60);
    rd(5'h0F, 1'b1, 32'd0);
    rd(5'h0F, 1'b1, 32'd1);

    // Out-of-range channel 4
    for (int a = 16; a < 20; a++) wr(5'(a), 32'hFFFF_FFFF);
    for (int a = 16; a < 20; a++) rd(5'(a), 1'b1, 32'h0);
    rd(5'h02, 1'b1, 32'h0000_0200);
    rd(5'h03, 1'b1, 32'd1);
    check("oor_irq", {31'b0, irq}, 32'h0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      for (int c = 0; c < NCH; c++) begin
        if ($urandom_range(0, 3) == 0)
          set_lvl(c, ($urandom_range(0, 15) == 0) ? 16'hFFFF : 16'($urandom_range(0, 255)));
      end
      op = $urandom_range(0, 9);
      if (op < 3) begin
        r = $urandom();
        wr(5'($urandom_range(0, 31)), r & 32'hFFFF_00FF);
      end else if (op < 7) begin
        rd(5'($urandom_range(0, 31)), 1'b0, 32'h0);
      end else begin
        tick();
      end
    end

    // Reset asserted mid-operation while irq is high
    wr(5'h0A, 32'd5);
    set_lvl(2, 0);
    wr(5'h0B, 32'd3);
    tick(); tick();
    set_lvl(2, 9); tick(); tick();
    check("pre_reset_irq", {31'b0, irq}, 32'h1);
    #2 reset_n = 1'b0;
    #1;
    check("midreset_readdata", bus.readdata, 32'h0);
    check("midreset_irq", {31'b0, irq}, 32'h0);
    tick(); tick();
    in_port = '0;
    reset_n = 1'b1;
    rd(5'h0A, 1'b1, 32'h0000_FFFF);
    rd(5'h0B, 1'b1, 32'h0);
    rd(5'h08, 1'b1, 32'h0);
    rd(5'h09, 1'b1, 32'h0);
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
